// File: rtl/mosaic_egress_adapter.sv
// Egress adapter MoSAIC -> shell: store-and-forward AXI-Stream FIFO that releases a packet
// only once it is complete, falling back to cut-through when a single packet fills the FIFO.
module mosaic_egress_adapter #(
   parameter int BW        = 32,
   parameter int BWB       = BW / 8,
   parameter int DEPTH     = 64,
   parameter int BP_THRESH = 4
) (
   input  logic           clk_line,
   input  logic           rst_n,
   input  logic           backpressure_in,
   output logic           backpressure_out,
   input  logic           stream_in_TLAST,
   input  logic           stream_in_TVALID,
   output logic           stream_in_TREADY,
   input  logic [BW-1:0]  stream_in_TDATA,
   input  logic [BWB-1:0] stream_in_TKEEP,
   output logic           stream_out_TLAST,
   output logic           stream_out_TVALID,
   input  logic           stream_out_TREADY,
   output logic [BW-1:0]  stream_out_TDATA,
   output logic [BWB-1:0] stream_out_TKEEP,
   output logic           cut_through_evt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = BW + BWB + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   logic [WW-1:0] r_mem [DEPTH];
   logic [CW-1:0] r_wr_ptr;
   logic [CW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_pkt_cnt;
   state_t        r_state;
   logic          r_ct_flag;
   logic          r_ct_evt;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_push_last;
   logic          w_pop_last;
   logic          w_tvalid;
   logic          w_ct_start;
   logic [WW-1:0] w_head;
   logic [CW-1:0] w_free;

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == CW'(0));
   assign w_free      = CW'(DEPTH) - r_count;
   assign w_push      = stream_in_TVALID & ~w_full;
   assign w_pop       = w_tvalid & stream_out_TREADY;
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_push_last = w_push & stream_in_TLAST;
   assign w_pop_last  = w_pop & w_head[WW-1];
   // A lone packet that fills the FIFO can never complete, so it must be let out early
   assign w_ct_start  = (r_state == ST_IDLE) & w_full & (r_pkt_cnt == CW'(0)) & ~r_ct_flag;

   assign stream_in_TREADY  = ~w_full;
   assign backpressure_out  = (w_free <= CW'(BP_THRESH));
   assign stream_out_TVALID = w_tvalid;
   assign stream_out_TLAST  = w_head[WW-1];
   assign stream_out_TKEEP  = w_head[BW +: BWB];
   assign stream_out_TDATA  = w_head[BW-1:0];
   assign cut_through_evt   = r_ct_evt;

   // Output valid: gated by shell backpressure only at a packet boundary
   always_comb begin
      w_tvalid = 1'b0;
      case (r_state)
         ST_IDLE: w_tvalid = ~w_empty & ~backpressure_in & ((r_pkt_cnt != CW'(0)) | r_ct_flag);
         ST_SEND: w_tvalid = ~w_empty;
         default: w_tvalid = 1'b0;
      endcase
   end

   // Packet storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk_line) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
      end
   end

   // Write/read pointers
   always_ff @(posedge clk_line or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= CW'(0);
         r_rd_ptr <= CW'(0);
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + CW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + CW'(1);
         end
      end
   end

   // Beat occupancy and complete-packet count
   always_ff @(posedge clk_line or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= CW'(0);
         r_pkt_cnt <= CW'(0);
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         case ({w_push_last, w_pop_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

   // Packet framing FSM with cut-through flag and event pulse
   always_ff @(posedge clk_line or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ct_flag <= 1'b0;
         r_ct_evt  <= 1'b0;
      end else begin
         r_ct_evt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  if (w_pop_last) begin
                     r_state   <= ST_IDLE;
                     r_ct_flag <= 1'b0;
                  end else begin
                     r_state <= ST_SEND;
                  end
               end else if (w_ct_start) begin
                  r_ct_flag <= 1'b1;
                  r_ct_evt  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SEND: begin
               if (w_pop_last) begin
                  r_state   <= ST_IDLE;
                  r_ct_flag <= 1'b0;
               end else begin
                  r_state <= ST_SEND;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_ct_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule
